// File: rtl/bomb_pkg.sv
// Shared types and defaults for the two-player bomb slot manager.
// A slot is one live bomb: who placed it, where, how many ticks remain, and whether it is due.
package bomb_pkg;

    typedef logic [7:0] coord_t;

    typedef enum logic {
        OWNER_P1 = 1'b0,
        OWNER_P2 = 1'b1
    } owner_e;

    typedef struct packed {
        logic       valid;
        owner_e     owner;
        coord_t     coord;
        logic [7:0] fuse;
        logic       expired;
    } slot_t;

    localparam int         N_SLOTS_DEF    = 6;
    localparam logic [7:0] FUSE_TICKS_DEF = 8'd150;

endpackage

// File: rtl/slot_pick.sv
// Lowest-index priority encoder: returns the one-hot of the lowest set request bit.
// Purely combinational; found is low and onehot is zero when no bit is set.
module slot_pick #(
    parameter int N = 6
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [N-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

    assign found = |req;

endmodule

// File: rtl/bomb_manager.sv
// Shared bomb slot table for two players: allocation, fuse countdown, chain detonation, explosion offer.
// An expiry is offered one cycle later and held stable until explode_ready; at most one transfer per 2 cycles.
module bomb_manager
    import bomb_pkg::*;
#(
    parameter int         N_SLOTS    = N_SLOTS_DEF,
    parameter logic [7:0] FUSE_TICKS = FUSE_TICKS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       set_bomb_1,
    input  logic       set_bomb_2,
    input  logic [7:0] coord_1,
    input  logic [7:0] coord_2,
    input  logic       detonate_valid,
    input  logic [7:0] detonate_coord,
    input  logic       explode_ready,
    output logic       explode_valid,
    output logic [7:0] explode_coord,
    output logic       explode_owner,
    output logic [2:0] bomb_num_1,
    output logic [2:0] bomb_num_2,
    output logic       drop_1,
    output logic       drop_2,
    input  logic [7:0] query_coord,
    output logic       query_hit
);

    typedef enum logic {ST_IDLE, ST_OFFER} state_e;

    slot_t              slot_q [N_SLOTS];
    slot_t              slot_d [N_SLOTS];
    state_e             state_q;
    logic [N_SLOTS-1:0] sel_q;
    logic               explode_valid_q;
    coord_t             explode_coord_q;
    owner_e             explode_owner_q;
    logic               drop_1_q, drop_1_d, drop_2_q, drop_2_d;
    logic [2:0]         bomb_num_1_q, bomb_num_1_d, bomb_num_2_q, bomb_num_2_d;

    logic [N_SLOTS-1:0] free_vec, free_2_vec, exp_vec;
    logic [N_SLOTS-1:0] hit_1_vec, hit_2_vec, hit_d_vec, hit_q_vec;
    logic [N_SLOTS-1:0] pick_1_oh, pick_2_oh, exp_oh;
    logic               pick_1_found, pick_2_found, exp_found;
    logic               accept_1, accept_2, xfer;
    coord_t             exp_coord;
    owner_e             exp_owner;

    always_comb begin
        free_vec  = '0;
        exp_vec   = '0;
        hit_1_vec = '0;
        hit_2_vec = '0;
        hit_d_vec = '0;
        hit_q_vec = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            free_vec[i]  = !slot_q[i].valid;
            exp_vec[i]   = slot_q[i].valid && slot_q[i].expired;
            hit_1_vec[i] = slot_q[i].valid && (slot_q[i].coord == coord_1);
            hit_2_vec[i] = slot_q[i].valid && (slot_q[i].coord == coord_2);
            hit_d_vec[i] = slot_q[i].valid && (slot_q[i].coord == detonate_coord);
            hit_q_vec[i] = slot_q[i].valid && (slot_q[i].coord == query_coord);
        end
    end

    slot_pick #(.N(N_SLOTS)) u_pick_1 (.req(free_vec), .found(pick_1_found), .onehot(pick_1_oh));

    // Player 2 sees the free set minus whatever player 1 takes this cycle.
    assign accept_1   = set_bomb_1 && !(|hit_1_vec) && pick_1_found;
    assign free_2_vec = accept_1 ? (free_vec & ~pick_1_oh) : free_vec;

    slot_pick #(.N(N_SLOTS)) u_pick_2 (.req(free_2_vec), .found(pick_2_found), .onehot(pick_2_oh));

    assign accept_2 = set_bomb_2 && !(|hit_2_vec) && !(set_bomb_1 && (coord_2 == coord_1))
                      && pick_2_found;
    assign drop_1_d = set_bomb_1 && !accept_1;
    assign drop_2_d = set_bomb_2 && !accept_2;

    slot_pick #(.N(N_SLOTS)) u_pick_exp (.req(exp_vec), .found(exp_found), .onehot(exp_oh));

    assign xfer      = (state_q == ST_OFFER) && explode_ready;
    assign query_hit = |hit_q_vec;

    always_comb begin
        exp_coord = '0;
        exp_owner = OWNER_P1;
        for (int i = 0; i < N_SLOTS; i++) begin
            slot_d[i] = slot_q[i];
            if (exp_oh[i]) begin
                exp_coord = slot_q[i].coord;
                exp_owner = slot_q[i].owner;
            end
            if (slot_q[i].valid && !slot_q[i].expired && tick) begin
                slot_d[i].fuse = slot_q[i].fuse - 8'd1;
                if (slot_q[i].fuse == 8'd1) slot_d[i].expired = 1'b1;
            end
            if (detonate_valid && hit_d_vec[i]) slot_d[i].expired = 1'b1;
            if (xfer && sel_q[i]) slot_d[i] = '0;
            if (accept_1 && pick_1_oh[i])
                slot_d[i] = '{valid: 1'b1, owner: OWNER_P1, coord: coord_1,
                              fuse: FUSE_TICKS, expired: 1'b0};
            if (accept_2 && pick_2_oh[i])
                slot_d[i] = '{valid: 1'b1, owner: OWNER_P2, coord: coord_2,
                              fuse: FUSE_TICKS, expired: 1'b0};
        end
    end

    // Counts include expired slots still waiting for the flame block.
    always_comb begin
        bomb_num_1_d = '0;
        bomb_num_2_d = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (slot_q[i].valid) begin
                if (slot_q[i].owner == OWNER_P1) bomb_num_1_d = bomb_num_1_d + 3'd1;
                else                             bomb_num_2_d = bomb_num_2_d + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SLOTS; i++) slot_q[i] <= '0;
            drop_1_q     <= 1'b0;
            drop_2_q     <= 1'b0;
            bomb_num_1_q <= '0;
            bomb_num_2_q <= '0;
        end else begin
            for (int i = 0; i < N_SLOTS; i++) slot_q[i] <= slot_d[i];
            drop_1_q     <= drop_1_d;
            drop_2_q     <= drop_2_d;
            bomb_num_1_q <= bomb_num_1_d;
            bomb_num_2_q <= bomb_num_2_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            sel_q           <= '0;
            explode_valid_q <= 1'b0;
            explode_coord_q <= '0;
            explode_owner_q <= OWNER_P1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (exp_found) begin
                        state_q         <= ST_OFFER;
                        sel_q           <= exp_oh;
                        explode_valid_q <= 1'b1;
                        explode_coord_q <= exp_coord;
                        explode_owner_q <= exp_owner;
                    end
                end
                ST_OFFER: begin
                    if (explode_ready) begin
                        state_q         <= ST_IDLE;
                        explode_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign explode_valid = explode_valid_q;
    assign explode_coord = explode_coord_q;
    assign explode_owner = explode_owner_q;
    assign bomb_num_1    = bomb_num_1_q;
    assign bomb_num_2    = bomb_num_2_q;
    assign drop_1        = drop_1_q;
    assign drop_2        = drop_2_q;

endmodule

// File: tb/tb_bomb_manager.sv
// Scoreboard bench: a bomb-list reference model predicts per-cycle outputs and the explosion order.
module tb_bomb_manager;

    localparam int NS = 6;
    localparam int FT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       set_bomb_1 = 1'b0, set_bomb_2 = 1'b0;
    logic [7:0] coord_1 = '0, coord_2 = '0;
    logic       detonate_valid = 1'b0;
    logic [7:0] detonate_coord = '0;
    logic       explode_ready = 1'b0;
    logic       explode_valid, explode_owner;
    logic [7:0] explode_coord;
    logic [2:0] bomb_num_1, bomb_num_2;
    logic       drop_1, drop_2;
    logic [7:0] query_coord = '0;
    logic       query_hit;

    always #5 clk = ~clk;

    bomb_manager #(.N_SLOTS(NS), .FUSE_TICKS(8'd3)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .set_bomb_1(set_bomb_1), .set_bomb_2(set_bomb_2),
        .coord_1(coord_1), .coord_2(coord_2),
        .detonate_valid(detonate_valid), .detonate_coord(detonate_coord),
        .explode_ready(explode_ready), .explode_valid(explode_valid),
        .explode_coord(explode_coord), .explode_owner(explode_owner),
        .bomb_num_1(bomb_num_1), .bomb_num_2(bomb_num_2),
        .drop_1(drop_1), .drop_2(drop_2),
        .query_coord(query_coord), .query_hit(query_hit)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit         ev;
        logic [7:0] ec;
        bit         eo;
        int         n1, n2;
        bit         d1, d2, qh;
    } exp_t;
    typedef struct {
        logic [7:0] c;
        bit         o;
    } xpl_t;

    exp_t eq[$];
    xpl_t xq[$];

    // Reference model: a table of live bombs plus the pending offer.
    bit         mv[NS], mo[NS], mx[NS];
    logic [7:0] mc[NS];
    int         mf[NS];
    bit         m_offer, m_eo, m_d1, m_d2;
    int         m_sel, m_n1, m_n2;
    logic [7:0] m_ec;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit holds(input logic [7:0] c);
        for (int i = 0; i < NS; i++) if (mv[i] && mc[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int lowest_free(input int skip);
        for (int i = 0; i < NS; i++) if (!mv[i] && i != skip) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            mv[i] = 0; mo[i] = 0; mx[i] = 0; mc[i] = '0; mf[i] = 0;
        end
        m_offer = 0; m_eo = 0; m_d1 = 0; m_d2 = 0; m_sel = 0; m_n1 = 0; m_n2 = 0; m_ec = '0;
    endtask

    task automatic model_step();
        int f1, f2, lowx, n1, n2;
        bit a1, a2, xfer;
        n1 = 0; n2 = 0; lowx = -1;
        for (int i = 0; i < NS; i++) if (mv[i]) begin
            if (mo[i]) n2++; else n1++;
        end
        for (int i = NS - 1; i >= 0; i--) if (mv[i] && mx[i]) lowx = i;
        xfer = m_offer && explode_ready;
        f1 = lowest_free(-1);
        a1 = set_bomb_1 && !holds(coord_1) && f1 >= 0;
        f2 = lowest_free(a1 ? f1 : -1);
        a2 = set_bomb_2 && !holds(coord_2) && !(set_bomb_1 && coord_1 == coord_2) && f2 >= 0;
        m_d1 = set_bomb_1 && !a1;
        m_d2 = set_bomb_2 && !a2;
        m_n1 = n1;
        m_n2 = n2;
        for (int i = 0; i < NS; i++) if (mv[i] && !mx[i]) begin
            if (detonate_valid && mc[i] == detonate_coord) mx[i] = 1;
            else if (tick) begin
                mf[i]--;
                if (mf[i] == 0) mx[i] = 1;
            end
        end
        if (xfer) begin
            mv[m_sel] = 0; mx[m_sel] = 0; m_offer = 0;
        end else if (!m_offer && lowx >= 0) begin
            m_offer = 1; m_sel = lowx; m_ec = mc[lowx]; m_eo = mo[lowx];
            xq.push_back('{c: mc[lowx], o: mo[lowx]});
        end
        if (a1) begin mv[f1] = 1; mo[f1] = 0; mc[f1] = coord_1; mf[f1] = FT; mx[f1] = 0; end
        if (a2) begin mv[f2] = 1; mo[f2] = 1; mc[f2] = coord_2; mf[f2] = FT; mx[f2] = 0; end
    endtask

    function automatic logic [7:0] pick_query();
        int i = $urandom_range(0, NS - 1);
        if (mv[i] && $urandom_range(0, 1) == 1) return mc[i];
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic cyc(input bit t, input bit s1, input logic [7:0] c1, input bit s2,
                       input logic [7:0] c2, input bit dv, input logic [7:0] dc, input bit rdy);
        exp_t e;
        tick = t; set_bomb_1 = s1; coord_1 = c1; set_bomb_2 = s2; coord_2 = c2;
        detonate_valid = dv; detonate_coord = dc; explode_ready = rdy;
        query_coord = pick_query();
        e.ev = m_offer; e.ec = m_ec; e.eo = m_eo; e.n1 = m_n1; e.n2 = m_n2;
        e.d1 = m_d1; e.d2 = m_d2; e.qh = holds(query_coord);
        eq.push_back(e);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n, input bit t, input bit rdy);
        for (int k = 0; k < n; k++) cyc(t, 0, 8'h00, 0, 8'h00, 0, 8'h00, rdy);
    endtask

    function automatic logic [7:0] rc();
        return 8'(8'h70 + $urandom_range(0, 9));
    endfunction

    initial begin : cycle_monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (eq.size() > 0) begin
                e = eq.pop_front();
                chk("explode_valid", 32'(explode_valid), 32'(e.ev));
                if (e.ev) begin
                    chk("explode_coord", 32'(explode_coord), 32'(e.ec));
                    chk("explode_owner", 32'(explode_owner), 32'(e.eo));
                end
                chk("bomb_num_1", 32'(bomb_num_1), 32'(e.n1));
                chk("bomb_num_2", 32'(bomb_num_2), 32'(e.n2));
                chk("drop_1", 32'(drop_1), 32'(e.d1));
                chk("drop_2", 32'(drop_2), 32'(e.d2));
                chk("query_hit", 32'(query_hit), 32'(e.qh));
            end
        end
    end

    initial begin : xfer_monitor
        xpl_t x;
        forever begin
            @(negedge clk);
            if (!rst && explode_valid === 1'b1 && explode_ready === 1'b1) begin
                if (xq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL xfer_order actual=unexpected coord %0h required=none @%0t",
                             explode_coord, $time);
                end else begin
                    x = xq.pop_front();
                    chk("xfer_coord", 32'(explode_coord), 32'(x.c));
                    chk("xfer_owner", 32'(explode_owner), 32'(x.o));
                end
            end
        end
    end

    initial begin : stimulus
        int hits;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_explode_valid", 32'(explode_valid), 32'd0);
        chk("rst_bomb_num_1", 32'(bomb_num_1), 32'd0);
        chk("rst_drop_1", 32'(drop_1), 32'd0);
        rst = 1'b0;

        // Single bomb through its full fuse.
        cyc(0, 1, 8'h11, 0, 8'h00, 0, 8'h00, 0);
        idle(1, 0, 0);
        chk("a_num1_after_set", 32'(bomb_num_1), 32'd1);
        idle(3, 1, 0);
        idle(1, 0, 0);
        chk("a_offer_valid", 32'(explode_valid), 32'd1);
        chk("a_offer_coord", 32'(explode_coord), 32'h11);
        chk("a_offer_owner", 32'(explode_owner), 32'd0);
        idle(1, 0, 1);
        idle(1, 0, 0);
        chk("a_num1_after_xfer", 32'(bomb_num_1), 32'd0);

        // Simultaneous placement on the same cell.
        cyc(0, 1, 8'h22, 1, 8'h22, 0, 8'h00, 0);
        chk("b_drop_2", 32'(drop_2), 32'd1);
        chk("b_drop_1", 32'(drop_1), 32'd0);
        cyc(0, 0, 8'h00, 0, 8'h00, 1, 8'h22, 0);
        chk("b_num1", 32'(bomb_num_1), 32'd1);
        chk("b_num2", 32'(bomb_num_2), 32'd0);
        idle(1, 0, 0);
        chk("b_offer_owner", 32'(explode_owner), 32'd0);
        idle(1, 0, 1);
        idle(1, 0, 0);

        // Fill every slot, overflow, then reuse a slot freed by a transfer.
        for (int i = 0; i < NS; i++)
            cyc(0, (i % 2) == 0, 8'(8'h40 + i), (i % 2) == 1, 8'(8'h40 + i), 0, 8'h00, 0);
        cyc(0, 1, 8'h50, 0, 8'h00, 0, 8'h00, 0);
        chk("c_full_drop", 32'(drop_1), 32'd1);
        cyc(0, 0, 8'h00, 0, 8'h00, 1, 8'h40, 0);
        idle(1, 0, 0);
        cyc(0, 1, 8'h51, 0, 8'h00, 0, 8'h00, 1);
        chk("c_set_in_xfer_cycle_drop", 32'(drop_1), 32'd1);
        cyc(0, 1, 8'h51, 0, 8'h00, 0, 8'h00, 0);
        chk("c_set_after_xfer_ok", 32'(drop_1), 32'd0);
        idle(20, 1, 1);

        // Two simultaneous expiries under backpressure.
        cyc(0, 1, 8'h60, 1, 8'h61, 0, 8'h00, 0);
        idle(3, 1, 0);
        idle(1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            chk("d_hold_valid", 32'(explode_valid), 32'd1);
            chk("d_hold_coord", 32'(explode_coord), 32'h60);
            idle(1, 0, 0);
        end
        idle(1, 0, 1);
        idle(1, 0, 0);
        chk("d_second_coord", 32'(explode_coord), 32'h61);
        idle(1, 0, 1);
        idle(1, 0, 0);

        // Chain detonation on a bomb with fuse remaining.
        cyc(0, 0, 8'h00, 1, 8'h35, 0, 8'h00, 0);
        idle(1, 1, 0);
        cyc(0, 0, 8'h00, 0, 8'h00, 1, 8'h35, 0);
        chk("e_not_yet_valid", 32'(explode_valid), 32'd0);
        idle(1, 0, 0);
        chk("e_det_valid", 32'(explode_valid), 32'd1);
        chk("e_det_coord", 32'(explode_coord), 32'h35);
        chk("e_det_owner", 32'(explode_owner), 32'd1);

        // Reset while the offer is pending.
        tick = 0; set_bomb_1 = 0; set_bomb_2 = 0; detonate_valid = 0; explode_ready = 0;
        rst = 1'b1;
        #1;
        chk("f_rst_valid", 32'(explode_valid), 32'd0);
        chk("f_rst_coord", 32'(explode_coord), 32'd0);
        chk("f_rst_owner", 32'(explode_owner), 32'd0);
        chk("f_rst_num2", 32'(bomb_num_2), 32'd0);
        chk("f_rst_drop2", 32'(drop_2), 32'd0);
        hits = 0;
        for (int c = 0; c < 256; c++) begin
            query_coord = 8'(c);
            #1;
            if (query_hit !== 1'b0) hits++;
        end
        chk("f_rst_query_hits", 32'(hits), 32'd0);
        model_reset();
        eq.delete();
        xq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < 1500; k++)
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, rc(),
                $urandom_range(0, 2) == 0, rc(), $urandom_range(0, 6) == 0, rc(),
                $urandom_range(0, 2) != 0);

        idle(30, 1, 1);
        idle(2, 0, 1);
        chk("end_num1", 32'(bomb_num_1), 32'd0);
        chk("end_num2", 32'(bomb_num_2), 32'd0);
        chk("end_pending_xfers", 32'(xq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
